// File: rtl/mod_doubler_reg.sv
// Registered modular doubler: oData = (2*iData) mod iMod for reduced operands.
// One pipeline stage with enable, synchronous clear, valid tag and range-error flag.
module mod_doubler_reg #(
  parameter int unsigned BITWIDTH = 32
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic                iClr,
  input  logic                iValid,
  input  logic [BITWIDTH-1:0] iData,
  input  logic [BITWIDTH-1:0] iMod,
  output logic                oValid,
  output logic [BITWIDTH-1:0] oData,
  output logic                oErr
);

  logic [BITWIDTH:0]   dbl;
  logic [BITWIDTH:0]   diff;
  logic                geMod;
  logic                rangeErr;
  logic [BITWIDTH-1:0] result;

  // The extra top bit of dbl keeps the doubling carry so the compare stays exact.
  always_comb begin
    dbl      = {iData, 1'b0};
    diff     = dbl - {1'b0, iMod};
    geMod    = (dbl >= {1'b0, iMod});
    rangeErr = (iData >= iMod);
    result   = '0;
    if (!rangeErr) begin
      result = geMod ? diff[BITWIDTH-1:0] : dbl[BITWIDTH-1:0];
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst || iClr) begin
      oValid <= 1'b0;
      oData  <= '0;
      oErr   <= 1'b0;
    end else if (iEn) begin
      oValid <= iValid;
      if (iValid) begin
        oData <= result;
        oErr  <= rangeErr;
      end
    end
  end

endmodule

// File: tb/tb_mod_doubler_reg.sv
// Directed self-checking bench for mod_doubler_reg; expected values are hand-computed.
`timescale 1ns/1ps
module tb_mod_doubler_reg;

  localparam int unsigned BW = 32;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iEn;
  logic          iClr;
  logic          iValid;
  logic [BW-1:0] iData;
  logic [BW-1:0] iMod;
  logic          oValid;
  logic [BW-1:0] oData;
  logic          oErr;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 iClk = ~iClk;

  mod_doubler_reg #(.BITWIDTH(BW)) dut (
    .iClk  (iClk),
    .iRst  (iRst),
    .iEn   (iEn),
    .iClr  (iClr),
    .iValid(iValid),
    .iData (iData),
    .iMod  (iMod),
    .oValid(oValid),
    .oData (oData),
    .oErr  (oErr)
  );

  // Advance one rising edge and settle past it before sampling outputs.
  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic test_reset();
    iRst = 1'b1; iClr = 1'b0; iEn = 1'b1; iValid = 1'b1;
    iData = 32'd5; iMod = 32'd23;
    for (int i = 0; i < 3; i++) begin
      step();
      testsRun++;
      if (oValid !== 1'b0 || oData !== 32'd0 || oErr !== 1'b0) begin
        testsFailed++;
        $display("FAIL reset_hold[%0d]: got v=%b d=%0d e=%b, want v=0 d=0 e=0",
                 i, oValid, oData, oErr);
      end
    end
    iRst = 1'b0;
    step();
    testsRun++;
    if (oValid !== 1'b1 || oData !== 32'd10 || oErr !== 1'b0) begin
      testsFailed++;
      $display("FAIL reset_release: got v=%b d=%0d e=%b, want v=1 d=10 e=0",
               oValid, oData, oErr);
    end
  endtask

  task automatic test_mod23();
    logic [BW-1:0] xs [5];
    logic [BW-1:0] ys [5];
    logic [BW-1:0] expd;
    int x;
    xs = '{32'd0, 32'd5, 32'd11, 32'd12, 32'd22};
    ys = '{32'd0, 32'd10, 32'd22, 32'd1, 32'd21};
    iMod = 32'd23; iValid = 1'b1; iEn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      iData = xs[i];
      step();
      testsRun++;
      if (oValid !== 1'b1 || oData !== ys[i] || oErr !== 1'b0) begin
        testsFailed++;
        $display("FAIL m23_directed x=%0d: got v=%b d=%0d e=%b, want v=1 d=%0d e=0",
                 xs[i], oValid, oData, oErr, ys[i]);
      end
    end
    for (int i = 0; i < 100; i++) begin
      x = int'($urandom_range(0, 22));
      iData = BW'(x);
      expd = BW'((2 * x) % 23);
      step();
      testsRun++;
      if (oValid !== 1'b1 || oData !== expd || oErr !== 1'b0) begin
        testsFailed++;
        $display("FAIL m23_random x=%0d: got v=%b d=%0d e=%b, want v=1 d=%0d e=0",
                 x, oValid, oData, oErr, expd);
      end
    end
  endtask

  task automatic test_carry();
    iValid = 1'b1; iEn = 1'b1;
    iMod = 32'hFFFF_FFFF; iData = 32'hFFFF_FFFE;
    step();
    testsRun++;
    if (oValid !== 1'b1 || oData !== 32'hFFFF_FFFD || oErr !== 1'b0) begin
      testsFailed++;
      $display("FAIL carry_max: got v=%b d=%h e=%b, want v=1 d=fffffffd e=0",
               oValid, oData, oErr);
    end
    iMod = 32'h8000_0001; iData = 32'h8000_0000;
    step();
    testsRun++;
    if (oValid !== 1'b1 || oData !== 32'h7FFF_FFFF || oErr !== 1'b0) begin
      testsFailed++;
      $display("FAIL carry_half: got v=%b d=%h e=%b, want v=1 d=7fffffff e=0",
               oValid, oData, oErr);
    end
    // Boundaries around M/2 for an odd modulus: floor((M-1)/2) and ceil(M/2).
    iMod = 32'd101; iData = 32'd50;
    step();
    testsRun++;
    if (oValid !== 1'b1 || oData !== 32'd100 || oErr !== 1'b0) begin
      testsFailed++;
      $display("FAIL half_floor: got v=%b d=%0d e=%b, want v=1 d=100 e=0",
               oValid, oData, oErr);
    end
    iData = 32'd51;
    step();
    testsRun++;
    if (oValid !== 1'b1 || oData !== 32'd1 || oErr !== 1'b0) begin
      testsFailed++;
      $display("FAIL half_ceil: got v=%b d=%0d e=%b, want v=1 d=1 e=0",
               oValid, oData, oErr);
    end
    iMod = 32'd1; iData = 32'd0;
    step();
    testsRun++;
    if (oValid !== 1'b1 || oData !== 32'd0 || oErr !== 1'b0) begin
      testsFailed++;
      $display("FAIL mod_one: got v=%b d=%0d e=%b, want v=1 d=0 e=0",
               oValid, oData, oErr);
    end
  endtask

  task automatic test_range_error();
    iValid = 1'b1; iEn = 1'b1;
    iMod = 32'd23; iData = 32'd23;
    step();
    testsRun++;
    if (oValid !== 1'b1 || oData !== 32'd0 || oErr !== 1'b1) begin
      testsFailed++;
      $display("FAIL err_x_eq_m: got v=%b d=%0d e=%b, want v=1 d=0 e=1",
               oValid, oData, oErr);
    end
    iMod = 32'd0; iData = 32'd0;
    step();
    testsRun++;
    if (oValid !== 1'b1 || oData !== 32'd0 || oErr !== 1'b1) begin
      testsFailed++;
      $display("FAIL err_m_zero: got v=%b d=%0d e=%b, want v=1 d=0 e=1",
               oValid, oData, oErr);
    end
    iMod = 32'd23; iData = 32'd4;
    step();
    testsRun++;
    if (oValid !== 1'b1 || oData !== 32'd8 || oErr !== 1'b0) begin
      testsFailed++;
      $display("FAIL err_recover: got v=%b d=%0d e=%b, want v=1 d=8 e=0",
               oValid, oData, oErr);
    end
  endtask

  task automatic test_control();
    iValid = 1'b1; iEn = 1'b1; iClr = 1'b0;
    iMod = 32'd23; iData = 32'd5;
    step();
    testsRun++;
    if (oValid !== 1'b1 || oData !== 32'd10 || oErr !== 1'b0) begin
      testsFailed++;
      $display("FAIL ctrl_load: got v=%b d=%0d e=%b, want v=1 d=10 e=0",
               oValid, oData, oErr);
    end
    iEn = 1'b0; iData = 32'd7; iValid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iData = iData + 32'd1; iValid = ~iValid;
      step();
      testsRun++;
      if (oValid !== 1'b1 || oData !== 32'd10 || oErr !== 1'b0) begin
        testsFailed++;
        $display("FAIL ctrl_freeze[%0d]: got v=%b d=%0d e=%b, want v=1 d=10 e=0",
                 i, oValid, oData, oErr);
      end
    end
    iEn = 1'b1; iValid = 1'b0; iData = 32'd9;
    step();
    testsRun++;
    if (oValid !== 1'b0 || oData !== 32'd10 || oErr !== 1'b0) begin
      testsFailed++;
      $display("FAIL ctrl_novalid: got v=%b d=%0d e=%b, want v=0 d=10 e=0",
               oValid, oData, oErr);
    end
    iClr = 1'b1; iValid = 1'b1; iData = 32'd3;
    step();
    testsRun++;
    if (oValid !== 1'b0 || oData !== 32'd0 || oErr !== 1'b0) begin
      testsFailed++;
      $display("FAIL ctrl_clear: got v=%b d=%0d e=%b, want v=0 d=0 e=0",
               oValid, oData, oErr);
    end
    iClr = 1'b0;
    step();
    testsRun++;
    if (oValid !== 1'b1 || oData !== 32'd6 || oErr !== 1'b0) begin
      testsFailed++;
      $display("FAIL ctrl_resume: got v=%b d=%0d e=%b, want v=1 d=6 e=0",
               oValid, oData, oErr);
    end
  endtask

  initial begin
    iRst = 1'b1; iClr = 1'b0; iEn = 1'b0; iValid = 1'b0;
    iData = '0; iMod = 32'd1;
    test_reset();
    test_mod23();
    test_carry();
    test_range_error();
    test_control();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
